// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared types, constants and helpers for the multi-channel PWM.
// Revision: 1.0  initial release
// ============================================================================
package pwm_pkg;

    localparam int unsigned c_default_width = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Index width that stays at least one bit wide for a single channel.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_channel
// Brief   : One PWM comparator with registered, polarity-adjusted output.
// Revision: 1.0  initial release
// ============================================================================
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    input  logic             polarity,
    output logic             pwm_out
);

    logic r_raw;
    logic r_pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw <= 1'b0;
        end else begin
            r_raw <= (cnt < duty);
        end
    end

    // Unreset so the idle level follows the pin while rst_n is held low.
    always_ff @(posedge clk) begin
        r_pol <= polarity;
    end

    assign pwm_out = r_raw ^ r_pol;

endmodule
`default_nettype wire

// File: rtl/pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module  : pwm_multi_channel
// Brief   : N-channel PWM with shared edge/center counter and shadowed settings.
// Revision: 1.0  initial release
// ============================================================================
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH    = c_default_width,
    parameter int CHANNELS = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            mode,
    input  logic                            period_wr,
    input  logic [WIDTH-1:0]                period_in,
    input  logic                            duty_wr,
    input  logic [clog2_min1(CHANNELS)-1:0] duty_chan,
    input  logic [WIDTH-1:0]                duty_in,
    input  logic [CHANNELS-1:0]             polarity,
    output logic [CHANNELS-1:0]             pwm_out,
    output logic                            period_start
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    state_e           r_state;
    pwm_mode_e        r_mode;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_period_sh;
    logic [WIDTH-1:0] r_duty    [CHANNELS];
    logic [WIDTH-1:0] r_duty_sh [CHANNELS];
    logic             w_boundary;
    logic             w_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_sh <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= '0;
            end
        end else begin
            if (period_wr) begin
                r_period_sh <= period_in;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (duty_wr && (int'(duty_chan) == i)) begin
                    r_duty_sh[i] <= duty_in;
                end
            end
        end
    end

    // A zero period reloads every cycle so a new nonzero value is picked up promptly.
    always_comb begin
        w_boundary = 1'b0;
        if (r_period == '0) begin
            w_boundary = 1'b1;
        end else if (r_mode == PWM_EDGE) begin
            w_boundary = (r_cnt == r_period - WIDTH'(1));
        end else begin
            w_boundary = (r_state == ST_DOWN) && (r_cnt == '0);
        end
    end

    assign w_active = en && (r_state != ST_IDLE) && (r_period != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= PWM_EDGE;
            r_cnt        <= '0;
            r_period     <= '0;
            period_start <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
        end else if (!en) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            period_start <= 1'b0;
        end else if ((r_state == ST_IDLE) || w_boundary) begin
            r_state      <= ST_UP;
            r_mode       <= pwm_mode_e'(mode);
            r_cnt        <= '0;
            r_period     <= r_period_sh;
            period_start <= (r_period_sh != '0);
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= r_duty_sh[i];
            end
        end else begin
            period_start <= 1'b0;
            case (r_state)
                ST_UP: begin
                    // Center mode holds the top count for a second cycle while turning.
                    if ((r_mode == PWM_CENTER) && (r_cnt == r_period - WIDTH'(1))) begin
                        r_state <= ST_DOWN;
                    end else begin
                        r_cnt <= r_cnt + WIDTH'(1);
                    end
                end
                ST_DOWN: begin
                    r_cnt <= r_cnt - WIDTH'(1);
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .cnt      (r_cnt),
            .duty     (w_active ? r_duty[g] : '0),
            .polarity (polarity[g]),
            .pwm_out  (pwm_out[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_multi_channel
// Brief   : Scoreboard bench for pwm_multi_channel (WIDTH=8, CHANNELS=4).
// Revision: 1.0  initial release
// ============================================================================
module tb_pwm_multi_channel;

    localparam int W   = 8;
    localparam int NCH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic         period_wr;
    logic [W-1:0] period_in;
    logic         duty_wr;
    logic [1:0]   duty_chan;
    logic [W-1:0] duty_in;
    logic [3:0]   polarity;
    logic [3:0]   pwm_out;
    logic         period_start;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .WIDTH    (W),
        .CHANNELS (NCH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .period_wr    (period_wr),
        .period_in    (period_in),
        .duty_wr      (duty_wr),
        .duty_chan    (duty_chan),
        .duty_in      (duty_in),
        .polarity     (polarity),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] pwm;
        logic       ps;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   s;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle the outputs are presented, pop what is due and compare.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d popped late at cycle %0d", e.name, e.cyc, cyc);
            end else if (pwm_out !== e.pwm || period_start !== e.ps) begin
                errors++;
                $display("FAIL %s cycle %0d: pwm_out=%b period_start=%b, expected pwm_out=%b period_start=%b",
                         e.name, cyc, pwm_out, period_start, e.pwm, e.ps);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0][7:0] dv(int a, int b, int c, int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    // Expected {period_start, pwm_out} for cycle j of a run whose first cycle (cnt=0) is j=0.
    // Output lags cnt by one cycle; duty d0 applies to periods before index sw, d1 afterwards.
    function automatic logic [4:0] model(int j, int p, bit center, logic [3:0][7:0] d0,
                                         logic [3:0][7:0] d1, int sw, logic [3:0] pol);
        int         len;
        int         k;
        int         m;
        int         c;
        logic [3:0] raw;
        logic       ps;
        raw = '0;
        ps  = 1'b0;
        if (p != 0) begin
            len = center ? 2 * p : p;
            ps  = (j % len == 0);
            if (j > 0) begin
                k = j - 1;
                m = k % len;
                c = (m < p) ? m : 2 * p - 1 - m;
                for (int i = 0; i < 4; i++) begin
                    raw[i] = (c < int'((k / len < sw) ? d0[i] : d1[i]));
                end
            end
        end
        return {ps, raw ^ pol};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic push_const(string name, int c0, int c1, logic [3:0] pwm, logic ps);
        for (int c = c0; c <= c1; c++) sb.push_back('{c, name, pwm, ps});
    endtask

    task automatic push_run(string name, int s0, int j0, int j1, int p, bit md,
                            logic [3:0][7:0] d0, logic [3:0][7:0] d1, int sw, logic [3:0] pol);
        logic [4:0] r;
        for (int j = j0; j < j1; j++) begin
            r = model(j, p, md, d0, d1, sw, pol);
            sb.push_back('{s0 + j, name, r[3:0], r[4]});
        end
    endtask

    // Stop, then load period and all four duties; first duty shares the cycle with the period write.
    task automatic setup(int p, bit md, logic [3:0][7:0] d, logic [3:0] pol);
        en        = 1'b0;
        mode      = md;
        polarity  = pol;
        period_wr = 1'b1;
        period_in = 8'(p);
        duty_wr   = 1'b1;
        duty_chan = 2'd0;
        duty_in   = d[0];
        tick();
        period_wr = 1'b0;
        for (int i = 1; i < 4; i++) begin
            duty_chan = 2'(i);
            duty_in   = d[i];
            tick();
        end
        duty_wr = 1'b0;
        tick();
    endtask

    task automatic write_duty(int ch, int d);
        duty_wr   = 1'b1;
        duty_chan = 2'(ch);
        duty_in   = 8'(d);
        tick();
        duty_wr = 1'b0;
    endtask

    task automatic run(string name, int p, bit md, logic [3:0][7:0] d, logic [3:0] pol, int n);
        setup(p, md, d, pol);
        en = 1'b1;
        s  = cyc + 1;
        push_run(name, s, 0, n, p, md, d, d, 0, pol);
        run_to(s + n - 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        period_wr = 1'b0;
        period_in = '0;
        duty_wr   = 1'b0;
        duty_chan = '0;
        duty_in   = '0;
        polarity  = 4'b0101;
        tick();
        push_const("reset_idle", cyc + 1, cyc + 3, 4'b0101, 1'b0);
        run_to(cyc + 3);
        rst_n = 1'b1;
        tick();

        run("edge_p10_d3",   10, 1'b0, dv(3, 0, 0, 0),    4'b0000, 31);
        run("center_p8_d2",   8, 1'b1, dv(0, 2, 0, 0),    4'b0100, 34);
        run("limits_inv",    10, 1'b0, dv(0, 10, 255, 4), 4'b0110, 21);
        run("limits",        10, 1'b0, dv(0, 10, 255, 4), 4'b0000, 21);
        run("period_zero",    0, 1'b0, dv(5, 5, 5, 5),    4'b0011, 12);
        run("edge_p1",        1, 1'b0, dv(1, 0, 0, 0),    4'b0000, 6);
        run("center_p1",      1, 1'b1, dv(1, 0, 2, 0),    4'b0000, 6);

        // Mid-period duty write takes effect at the next period.
        setup(10, 1'b0, dv(3, 0, 0, 0), 4'b0000);
        en = 1'b1;
        s  = cyc + 1;
        push_run("shadow_mid", s, 0, 30, 10, 1'b0, dv(3, 0, 0, 0), dv(7, 0, 0, 0), 1, 4'b0000);
        run_to(s + 4);
        write_duty(0, 7);
        run_to(s + 29);

        // Write in the boundary cycle is missed by that reload.
        setup(10, 1'b0, dv(3, 0, 0, 0), 4'b0000);
        en = 1'b1;
        s  = cyc + 1;
        push_run("shadow_boundary", s, 0, 32, 10, 1'b0, dv(3, 0, 0, 0), dv(7, 0, 0, 0), 2, 4'b0000);
        run_to(s + 9);
        write_duty(0, 7);
        run_to(s + 31);

        // Drop en mid-pulse, rewrite the duty while stopped, then restart.
        setup(10, 1'b0, dv(5, 0, 0, 0), 4'b0000);
        en = 1'b1;
        s  = cyc + 1;
        push_run("en_drop", s, 0, 3, 10, 1'b0, dv(5, 0, 0, 0), dv(5, 0, 0, 0), 0, 4'b0000);
        run_to(s + 2);
        en = 1'b0;
        push_const("en_low_idle", s + 3, s + 6, 4'b0000, 1'b0);
        run_to(s + 6);
        write_duty(0, 2);
        tick();
        en = 1'b1;
        s  = cyc + 1;
        push_run("en_restart", s, 0, 21, 10, 1'b0, dv(2, 0, 0, 0), dv(2, 0, 0, 0), 0, 4'b0000);
        run_to(s + 20);

        // Asynchronous reset in the middle of a high pulse.
        setup(10, 1'b0, dv(5, 0, 0, 5), 4'b1000);
        en = 1'b1;
        s  = cyc + 1;
        push_run("pre_reset", s, 0, 2, 10, 1'b0, dv(5, 0, 0, 5), dv(5, 0, 0, 5), 0, 4'b1000);
        push_const("async_reset", s + 2, s + 2, 4'b1000, 1'b0);
        push_const("post_reset_idle", s + 3, s + 12, 4'b1000, 1'b0);
        run_to(s + 2);
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        run_to(s + 12);

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
